// File: rtl/norm_arbiter_if.sv
// Request/encoder/response bundle shared by the adder lanes, the shared
// leading-one encoder and the normalise arbiter.
interface norm_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    ReqValid;
  logic [NUM_REQ-1:0]    ReqReady;
  logic [NUM_REQ*25-1:0] ReqMant;
  logic [NUM_REQ*8-1:0]  ReqExp;
  logic [24:0]           PeDataIn;
  logic [4:0]            PeDataOut;
  logic                  RspValid;
  logic                  RspReady;
  logic [ID_W-1:0]       RspId;
  logic [22:0]           RspMant;
  logic [7:0]            RspExp;
  logic                  RspZero;
  logic                  RspOvf;
  logic                  RspUnf;
  logic                  Busy;

  // Arbiter side
  modport slave (
    input  ReqValid, ReqMant, ReqExp, PeDataOut, RspReady,
    output ReqReady, PeDataIn, RspValid, RspId, RspMant, RspExp,
           RspZero, RspOvf, RspUnf, Busy
  );

  // Lanes / encoder / downstream side
  modport master (
    output ReqValid, ReqMant, ReqExp, PeDataOut, RspReady,
    input  ReqReady, PeDataIn, RspValid, RspId, RspMant, RspExp,
           RspZero, RspOvf, RspUnf, Busy
  );
endinterface

// File: rtl/norm_arbiter.sv
// Shares one leading-one encoder and normalising shifter between NUM_REQ lanes.
// Define NORM_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module norm_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic          Clk,
  input  logic          Rst,
  norm_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ENC, SHIFT, RESP} state_t;

  typedef struct packed {
    logic [22:0] mant;
    logic [7:0]  exp;
    logic        zero;
    logic        ovf;
    logic        unf;
  } rsp_t;

  state_t state, state_nxt;

  logic            gnt_any;
  logic [ID_W-1:0] gnt_id;
  logic            take;
  int              idx;

  logic [24:0]     mant_p0;
  logic [7:0]      exp_p0;
  logic [ID_W-1:0] id_p0;
  logic [4:0]      pos_p1;
  logic            zero_p1;
  rsp_t            nrm;

  // Bring the hidden bit to position 23 and saturate the exponent.
  function automatic rsp_t normalise(input logic [24:0] mant, input logic [7:0] e,
                                     input logic [4:0] pos, input logic zero);
    rsp_t             r;
    logic signed [9:0] e_s;
    logic [24:0]      m_sh;
    logic [4:0]       s;
    r    = '0;
    m_sh = '0;
    s    = 5'd23 - pos;
    e_s  = signed'({2'b00, e});
    if (zero) begin
      r.zero = 1'b1;
    end else if (pos == 5'd24) begin
      if (e >= 8'd254) begin
        r.ovf = 1'b1;
        r.exp = 8'd255;
      end else begin
        m_sh   = mant >> 1;
        r.mant = m_sh[22:0];
        r.exp  = e + 8'd1;
      end
    end else if (pos < 5'd23) begin
      e_s = e_s - signed'({5'b00000, s});
      if (e_s <= 0) begin
        r.unf = 1'b1;
      end else begin
        m_sh   = mant << s;
        r.mant = m_sh[22:0];
        r.exp  = e_s[7:0];
      end
    end else begin
      r.mant = mant[22:0];
      r.exp  = e;
    end
    return r;
  endfunction

`ifdef NORM_ARB_RR_EN
  logic [ID_W-1:0] rr_ptr;

  // Reverse scan so the first valid lane at or after the pointer wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (bus.ReqValid[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst)
      rr_ptr <= '0;
    else if (take)
      rr_ptr <= (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + 1'b1;
  end
`else
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.ReqValid[k]) begin
        gnt_any = 1'b1;
        gnt_id  = ID_W'(k);
        idx     = k;
      end
    end
  end
`endif

  assign take         = (state == IDLE) && gnt_any && !Rst;
  assign bus.ReqReady = take ? (NUM_REQ'(1) << gnt_id) : '0;
  assign bus.PeDataIn = (state != IDLE) ? mant_p0 : '0;
  assign bus.Busy     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (gnt_any) state_nxt = ENC;
      ENC:     state_nxt = SHIFT;
      SHIFT:   state_nxt = RESP;
      RESP:    if (bus.RspReady) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // p0: capture the granted lane
  always_ff @(posedge Clk) begin
    if (take) begin
      mant_p0 <= bus.ReqMant[25*int'(gnt_id) +: 25];
      exp_p0  <= bus.ReqExp[8*int'(gnt_id) +: 8];
      id_p0   <= gnt_id;
    end
  end

  // p1: encoder result; zero is taken from the mantissa, not the encoder's 23
  always_ff @(posedge Clk) begin
    if (state == ENC) begin
      pos_p1  <= bus.PeDataOut;
      zero_p1 <= (mant_p0 == 25'd0);
    end
  end

  assign nrm = normalise(mant_p0, exp_p0, pos_p1, zero_p1);

  // p2: response register, held until accepted
  always_ff @(posedge Clk) begin
    if (Rst) begin
      bus.RspValid <= 1'b0;
      bus.RspId    <= '0;
      bus.RspMant  <= '0;
      bus.RspExp   <= '0;
      bus.RspZero  <= 1'b0;
      bus.RspOvf   <= 1'b0;
      bus.RspUnf   <= 1'b0;
    end else if (state == SHIFT) begin
      bus.RspValid <= 1'b1;
      bus.RspId    <= id_p0;
      bus.RspMant  <= nrm.mant;
      bus.RspExp   <= nrm.exp;
      bus.RspZero  <= nrm.zero;
      bus.RspOvf   <= nrm.ovf;
      bus.RspUnf   <= nrm.unf;
    end else if (state == RESP && bus.RspReady) begin
      bus.RspValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_norm_arbiter.sv
// Self-checking bench for norm_arbiter: directed cases plus randomized traffic
// against a value-level normalisation and arbitration model.
module tb_norm_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  typedef struct {
    logic [22:0] mant;
    logic [7:0]  exp;
    logic        zero;
    logic        ovf;
    logic        unf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   ptr = 0;

  logic [24:0] lm [NUM_REQ];
  logic [7:0]  le [NUM_REQ];

  logic [22:0]     last_mant;
  logic [7:0]      last_exp;
  logic [ID_W-1:0] last_id;
  logic            last_zero, last_ovf, last_unf;

  norm_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  norm_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Shared leading-one encoder: MSB index, 23 for zero input
  function automatic logic [4:0] enc(input logic [24:0] d);
    logic [4:0] p;
    p = 5'd23;
    for (int i = 0; i < 25; i++) if (d[i]) p = 5'(i);
    return p;
  endfunction

  always_comb bus.PeDataOut = enc(bus.PeDataIn);

  function automatic exp_t ref_norm(input logic [24:0] m, input logic [7:0] e);
    exp_t   r;
    int     p, en;
    longint v;
    r.mant = '0; r.exp = '0; r.zero = 1'b0; r.ovf = 1'b0; r.unf = 1'b0;
    if (m == 25'd0) begin
      r.zero = 1'b1;
      return r;
    end
    p = 0;
    for (int i = 0; i < 25; i++) if (m[i]) p = i;
    en = int'(e) + p - 23;
    if (p == 24 && en >= 255) begin
      r.ovf = 1'b1;
      r.exp = 8'd255;
    end else if (p < 23 && en <= 0) begin
      r.unf = 1'b1;
    end else begin
      v = longint'(m);
      v = (p >= 23) ? (v >> (p - 23)) : (v << (23 - p));
      r.mant = v[22:0];
      r.exp  = en[7:0];
    end
    return r;
  endfunction

  function automatic int pick(input logic [NUM_REQ-1:0] mask, input int p);
    int idx;
`ifdef NORM_ARB_RR_EN
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (p + k) % NUM_REQ;
      if (mask[idx]) return idx;
    end
`else
    idx = p;
    for (int k = 0; k < NUM_REQ; k++) if (mask[k]) return k;
`endif
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic [NUM_REQ-1:0] mask);
    bus.ReqValid = mask;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.ReqMant[25*i +: 25] = lm[i];
      bus.ReqExp[8*i +: 8]    = le[i];
    end
  endtask

  task automatic gen_lane(input int i);
    int k, sel;
    k = $urandom_range(0, 26);
    if (k > 24) lm[i] = 25'd0;
    else        lm[i] = (25'($urandom) & ((25'd1 << k) - 25'd1)) | (25'd1 << k);
    sel = $urandom_range(0, 3);
    if (sel == 0)      le[i] = 8'($urandom_range(0, 30));
    else if (sel == 1) le[i] = 8'($urandom_range(240, 255));
    else               le[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_rspvalid"}, bus.RspValid, 0);
    chk({tag, "_rspid"},    bus.RspId, 0);
    chk({tag, "_rspmant"},  bus.RspMant, 0);
    chk({tag, "_rspexp"},   bus.RspExp, 0);
    chk({tag, "_flags"},    {bus.RspZero, bus.RspOvf, bus.RspUnf}, 0);
    chk({tag, "_busy"},     bus.Busy, 0);
    chk({tag, "_reqready"}, bus.ReqReady, 0);
    chk({tag, "_pedatain"}, bus.PeDataIn, 0);
  endtask

  task automatic do_reset();
    drive('0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    ptr = 0;
    #1;
    chk_zero_outputs("reset");
  endtask

  task automatic wait_grant();
    int n;
    n = 0;
    while (bus.ReqReady == '0 && n < 10) begin
      tick();
      n++;
    end
    chk("grant_seen", (bus.ReqReady != '0), 1);
  endtask

  // One transaction from request to accepted response, with optional RESP stall
  task automatic txn(input logic [NUM_REQ-1:0] mask, input int stall);
    int                 g, t0, n;
    exp_t               e;
    logic [NUM_REQ-1:0] oh;
    logic [22:0]        hm;
    logic [7:0]         he;
    bus.RspReady = (stall == 0);
    drive(mask);
    #1;
    wait_grant();
    g  = pick(mask, ptr);
    oh = NUM_REQ'(1) << g;
    chk("grant_onehot", bus.ReqReady, oh);
    e  = ref_norm(lm[g], le[g]);
    t0 = cyc;
`ifdef NORM_ARB_RR_EN
    ptr = (g + 1) % NUM_REQ;
`endif
    tick();
    drive('0);
    #1;
    chk("pe_data_in", bus.PeDataIn, lm[g]);
    chk("enc_reqready", bus.ReqReady, 0);
    n = 0;
    while (!bus.RspValid && n < 10) begin
      tick();
      n++;
    end
    chk("latency", cyc - t0, 3);
    chk("rsp_id",   bus.RspId, g);
    chk("rsp_mant", bus.RspMant, e.mant);
    chk("rsp_exp",  bus.RspExp, e.exp);
    chk("rsp_zero", bus.RspZero, e.zero);
    chk("rsp_ovf",  bus.RspOvf, e.ovf);
    chk("rsp_unf",  bus.RspUnf, e.unf);
    chk("rsp_busy", bus.Busy, 1);
    last_mant = bus.RspMant; last_exp = bus.RspExp; last_id = bus.RspId;
    last_zero = bus.RspZero; last_ovf = bus.RspOvf; last_unf = bus.RspUnf;
    hm = bus.RspMant;
    he = bus.RspExp;
    for (int s = 0; s < stall; s++) begin
      drive('1);
      #1;
      chk("stall_valid",    bus.RspValid, 1);
      chk("stall_fields",   {bus.RspId, bus.RspMant, bus.RspExp}, {last_id, hm, he});
      chk("stall_busy",     bus.Busy, 1);
      chk("stall_reqready", bus.ReqReady, 0);
      tick();
    end
    drive('0);
    bus.RspReady = 1'b1;
    tick();
    chk("rsp_drop", bus.RspValid, 0);
    chk("idle_busy", bus.Busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int                 g, tprev;
    exp_t               e;
    logic [NUM_REQ-1:0] mask;

    for (int i = 0; i < NUM_REQ; i++) begin
      lm[i] = '0;
      le[i] = '0;
    end
    bus.RspReady = 1'b0;
    drive('0);
    do_reset();

    // Case 1: already normalised
    lm[0] = 25'h0800000; le[0] = 8'd127;
    txn(4'b0001, 0);
    chk("t1_mant", last_mant, 0);
    chk("t1_exp",  last_exp, 127);
    chk("t1_id",   last_id, 0);

    // Case 2: carry out, then overflow
    lm[0] = 25'h1000000; le[0] = 8'd127;
    txn(4'b0001, 0);
    chk("t2_exp", last_exp, 128);
    chk("t2_mant", last_mant, 0);
    le[0] = 8'd254;
    txn(4'b0001, 0);
    chk("t2_ovf", {last_ovf, last_exp, last_mant}, {1'b1, 8'd255, 23'd0});

    // Case 3: long left shift, underflow, zero
    lm[3] = 25'h0000001; le[3] = 8'd100;
    txn(4'b1000, 0);
    chk("t3_exp", last_exp, 77);
    chk("t3_id",  last_id, 3);
    lm[0] = 25'h0000001; le[0] = 8'd23;
    txn(4'b0001, 0);
    chk("t3_unf", {last_unf, last_exp, last_mant}, {1'b1, 8'd0, 23'd0});
    lm[0] = 25'h0; le[0] = 8'd50;
    txn(4'b0001, 0);
    chk("t3_zero", {last_zero, last_exp, last_mant, last_ovf, last_unf}, {1'b1, 8'd0, 23'd0, 2'b00});

    // Case 4: all lanes requesting continuously
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) gen_lane(i);
    bus.RspReady = 1'b1;
    drive('1);
    #1;
    tprev = 0;
    for (int t = 0; t < 5; t++) begin
      wait_grant();
      g = pick('1, ptr);
      chk("t4_grant", bus.ReqReady, NUM_REQ'(1) << g);
      if (t > 0) chk("t4_gap", cyc - tprev, 4);
      tprev = cyc;
`ifdef NORM_ARB_RR_EN
      ptr = (g + 1) % NUM_REQ;
`endif
      e = ref_norm(lm[g], le[g]);
      tick();
      for (int n = 0; n < 10 && !bus.RspValid; n++) tick();
      chk("t4_id",   bus.RspId, g);
      chk("t4_mant", bus.RspMant, e.mant);
      chk("t4_exp",  bus.RspExp, e.exp);
      tick();
    end
    drive('0);
    for (int n = 0; n < 10 && bus.Busy; n++) tick();
    chk("t4_idle", bus.Busy, 0);

    // Case 5: downstream stall in RESP
    gen_lane(1);
    txn(4'b0010, 5);

    // Case 6: reset during SHIFT
    lm[2] = 25'h0400000; le[2] = 8'd90;
    drive(4'b0100);
    #1;
    wait_grant();
    chk("t6_grant", bus.ReqReady, 4'b0100);
    tick();
    drive('0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ptr = 0;
    #1;
    chk_zero_outputs("t6_abort");
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("t6_no_rsp", bus.RspValid, 0);
    end
    for (int i = 0; i < NUM_REQ; i++) gen_lane(i);
    txn(4'b1111, 0);
    chk("t6_first_lane", last_id, 0);

    // Randomized traffic
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < NUM_REQ; i++) gen_lane(i);
      mask = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      txn(mask, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
